// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter.
//   NUM_SRC    : number of result producers (0=RS, 1=LSB, 2=BR)
//   ROB_IDX_W  : ROB tag width
//   DATA_W     : result value width
//   SRC_IDX_W  : width of a source index (cdb_src_out)
//   rr_next()  : advance a round-robin pointer past a winner, wrapping at NUM_SRC
package cdb_arbiter_pkg;
    localparam int NUM_SRC   = 3;
    localparam int ROB_IDX_W = 4;
    localparam int DATA_W    = 32;
    localparam int SRC_IDX_W = 2;

    localparam logic [SRC_IDX_W-1:0] CDB_SRC_RS  = 2'd0;
    localparam logic [SRC_IDX_W-1:0] CDB_SRC_LSB = 2'd1;
    localparam logic [SRC_IDX_W-1:0] CDB_SRC_BR  = 2'd2;

    function automatic logic [SRC_IDX_W-1:0] rr_next(input logic [SRC_IDX_W-1:0] idx);
        return (idx == SRC_IDX_W'(NUM_SRC - 1)) ? '0 : idx + 1'b1;
    endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer/CDB bundle of the common-data-bus arbiter.
//   src_valid_in   : per-source result valid
//   src_rob_idx_in : per-source ROB tag, source i at [i*ROB_IDX_W +: ROB_IDX_W]
//   src_val_in     : per-source value, packed the same way
//   src_ready_out  : source i may present a result this cycle
//   cdb_en_out / cdb_rob_idx_out / cdb_val_out / cdb_src_out : registered broadcast
// Modports: master = producers and CDB consumers, slave = the arbiter.
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    logic [NUM_SRC-1:0]           src_valid_in;
    logic [NUM_SRC*ROB_IDX_W-1:0] src_rob_idx_in;
    logic [NUM_SRC*DATA_W-1:0]    src_val_in;
    logic [NUM_SRC-1:0]           src_ready_out;
    logic                         cdb_en_out;
    logic [ROB_IDX_W-1:0]         cdb_rob_idx_out;
    logic [DATA_W-1:0]            cdb_val_out;
    logic [SRC_IDX_W-1:0]         cdb_src_out;

    modport master (
        output src_valid_in, src_rob_idx_in, src_val_in,
        input  src_ready_out, cdb_en_out, cdb_rob_idx_out, cdb_val_out, cdb_src_out
    );

    modport slave (
        input  src_valid_in, src_rob_idx_in, src_val_in,
        output src_ready_out, cdb_en_out, cdb_rob_idx_out, cdb_val_out, cdb_src_out
    );
endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first set bit of i_cand scanning
// upward from i_ptr with wrap-around. Also used by the LSB memory-port arbiter.
//   i_cand  : candidate request vector
//   i_ptr   : highest-priority index
//   o_grant : one-hot grant (all zero when no candidate)
//   o_idx   : index of the granted bit
//   o_any   : at least one candidate
module cdb_arbiter_rr_picker #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_cand,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    logic [IW-1:0] w_j;

    // Scan from the farthest position toward i_ptr so the nearest candidate is written last.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = IW'((int'(i_ptr) + k) % N);
            if (i_cand[w_j]) begin
                o_grant      = '0;
                o_grant[w_j] = 1'b1;
                o_idx        = w_j;
                o_any        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: each result source owns a one-entry holding buffer and a
// round-robin scheduler broadcasts one result per cycle on the registered CDB.
// Ports:
//   clk       : system clock, posedge
//   rst_in    : synchronous active-low reset
//   rdy_in    : pause, all state holds while low (including a pending roll_back)
//   roll_back : mispredict flush, empties buffers and kills the broadcast
//   bus       : cdb_arbiter_if.slave (producer handshake + CDB broadcast)
// Build option: define CDB_BYPASS_EN to let a winning source with an empty buffer go
// straight into the CDB register (1-cycle latency); default is a fixed 2-cycle path.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input logic          clk,
    input logic          rst_in,
    input logic          rdy_in,
    input logic          roll_back,
    cdb_arbiter_if.slave bus
);
    logic [NUM_SRC-1:0]   w_cand, w_grant, w_ready, w_acc, w_byp, w_load;
    logic [SRC_IDX_W-1:0] w_win_idx;
    logic                 w_win_any;
    logic [ROB_IDX_W-1:0] w_win_tag;
    logic [DATA_W-1:0]    w_win_val;
    logic [ROB_IDX_W-1:0] w_in_tag [NUM_SRC];
    logic [DATA_W-1:0]    w_in_val [NUM_SRC];

    logic [NUM_SRC-1:0]   r_vld_p0;
    logic [ROB_IDX_W-1:0] r_tag_p0 [NUM_SRC];
    logic [DATA_W-1:0]    r_val_p0 [NUM_SRC];
    logic [SRC_IDX_W-1:0] r_rr_ptr;
    logic                 r_vld_p1;
    logic [ROB_IDX_W-1:0] r_tag_p1;
    logic [DATA_W-1:0]    r_val_p1;
    logic [SRC_IDX_W-1:0] r_src_p1;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            w_in_tag[i] = bus.src_rob_idx_in[i*ROB_IDX_W +: ROB_IDX_W];
            w_in_val[i] = bus.src_val_in[i*DATA_W +: DATA_W];
        end
    end

`ifdef CDB_BYPASS_EN
    assign w_cand = r_vld_p0 | (bus.src_valid_in & ~r_vld_p0 & {NUM_SRC{rdy_in}});
`else
    assign w_cand = r_vld_p0;
`endif

    cdb_arbiter_rr_picker #(.N(NUM_SRC), .IW(SRC_IDX_W)) u_pick (
        .i_cand  (w_cand),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_win_idx),
        .o_any   (w_win_any)
    );

    // A granted source with an empty buffer can only be a bypass winner.
    assign w_byp   = w_grant & ~r_vld_p0;
    assign w_ready = {NUM_SRC{rdy_in && !roll_back}} & (~r_vld_p0 | w_grant);
    assign w_acc   = bus.src_valid_in & w_ready;
    assign w_load  = w_acc & ~w_byp;

    always_comb begin
        w_win_tag = r_tag_p0[w_win_idx];
        w_win_val = r_val_p0[w_win_idx];
`ifdef CDB_BYPASS_EN
        if (!r_vld_p0[w_win_idx]) begin
            w_win_tag = w_in_tag[w_win_idx];
            w_win_val = w_in_val[w_win_idx];
        end
`endif
    end

    // Stage p0: holding buffers; a grant and a refill on the same edge keep the entry full.
    always_ff @(posedge clk) begin
        if (rdy_in && !roll_back) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_load[i]) begin
                    r_tag_p0[i] <= w_in_tag[i];
                    r_val_p0[i] <= w_in_val[i];
                end
            end
        end
    end

    // Stage p1: occupancy, round-robin pointer and the registered CDB broadcast.
    always_ff @(posedge clk) begin
        if (!rst_in) begin
            r_vld_p0 <= '0;
            r_rr_ptr <= '0;
            r_vld_p1 <= 1'b0;
            r_tag_p1 <= '0;
            r_val_p1 <= '0;
            r_src_p1 <= '0;
        end else if (rdy_in) begin
            if (roll_back) begin
                r_vld_p0 <= '0;
                r_vld_p1 <= 1'b0;
                r_tag_p1 <= '0;
                r_val_p1 <= '0;
                r_src_p1 <= '0;
            end else begin
                r_vld_p0 <= (r_vld_p0 & ~w_grant) | w_load;
                if (w_win_any) begin
                    r_rr_ptr <= rr_next(w_win_idx);
                    r_vld_p1 <= 1'b1;
                    r_tag_p1 <= w_win_tag;
                    r_val_p1 <= w_win_val;
                    r_src_p1 <= w_win_idx;
                end else begin
                    r_vld_p1 <= 1'b0;
                    r_tag_p1 <= '0;
                    r_val_p1 <= '0;
                    r_src_p1 <= '0;
                end
            end
        end
    end

    assign bus.src_ready_out   = w_ready;
    assign bus.cdb_en_out      = r_vld_p1;
    assign bus.cdb_rob_idx_out = r_tag_p1;
    assign bus.cdb_val_out     = r_val_p1;
    assign bus.cdb_src_out     = r_src_p1;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: per-source scoreboard queues filled on accept and
// drained on each broadcast, plus directed timing checks per scenario.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

`ifdef CDB_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;
    logic roll_back = 1'b0;

    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .clk       (clk),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .roll_back (roll_back),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [35:0]  sb_q [NUM_SRC][$];
    logic [2:0]   last_ready, last_acc;
    logic         obs_en;
    logic [3:0]   obs_tag;
    logic [31:0]  obs_val;
    logic [1:0]   obs_src;

    task automatic present(input int s, input logic [3:0] tag, input logic [31:0] val);
        bus.src_valid_in[s]           = 1'b1;
        bus.src_rob_idx_in[s*4 +: 4]  = tag;
        bus.src_val_in[s*32 +: 32]    = val;
    endtask

    task automatic clear_sb();
        for (int s = 0; s < NUM_SRC; s++) sb_q[s].delete();
    endtask

    // One clock: record accepts at negedge, sample the CDB 1 time unit after posedge.
    task automatic tick();
        logic live;
        logic [35:0] exp;
        @(negedge clk);
        last_ready = bus.src_ready_out;
        last_acc   = bus.src_valid_in & bus.src_ready_out;
        live       = rdy_in && rst_in;
        for (int s = 0; s < NUM_SRC; s++)
            if (last_acc[s] && rst_in)
                sb_q[s].push_back({bus.src_rob_idx_in[s*4 +: 4], bus.src_val_in[s*32 +: 32]});
        @(posedge clk);
        #1;
        obs_en  = bus.cdb_en_out;
        obs_tag = bus.cdb_rob_idx_out;
        obs_val = bus.cdb_val_out;
        obs_src = bus.cdb_src_out;
        bus.src_valid_in = bus.src_valid_in & ~last_acc;
        if (live && obs_en) begin
            n_vec++;
            if (int'(obs_src) >= NUM_SRC || sb_q[obs_src].size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got src %0d tag %0d val %h, required no broadcast",
                         obs_src, obs_tag, obs_val);
            end else begin
                exp = sb_q[obs_src].pop_front();
                if ({obs_tag, obs_val} !== exp) begin
                    n_err++;
                    $display("FAIL sb_order src %0d: got tag %0d val %h, required tag %0d val %h",
                             obs_src, obs_tag, obs_val, exp[35:32], exp[31:0]);
                end
            end
        end
    endtask

    task automatic do_reset();
        bus.src_valid_in = '0;
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        clear_sb();
    endtask

    task automatic test_reset();
        bus.src_valid_in   = '0;
        bus.src_rob_idx_in = '0;
        bus.src_val_in     = '0;
        rst_in = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_vec++;
            if ({obs_en, obs_tag, obs_val, obs_src} !== 39'd0) begin
                n_err++;
                $display("FAIL reset_cdb: got en %b tag %0d val %h src %0d, required all 0",
                         obs_en, obs_tag, obs_val, obs_src);
            end
        end
        rst_in = 1'b1;
        tick();
        n_vec++;
        if (last_ready !== 3'b111) begin
            n_err++;
            $display("FAIL reset_ready: got %b, required 111", last_ready);
        end
        n_vec++;
        if (obs_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_en: got %b, required 0", obs_en);
        end
    endtask

    task automatic test_single();
        logic exp_en;
        present(0, 4'd5, 32'h0000_0011);
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_en = (k == LAT);
            n_vec++;
            if (obs_en !== exp_en ||
                (exp_en && (obs_tag !== 4'd5 || obs_val !== 32'h11 || obs_src !== 2'd0))) begin
                n_err++;
                $display("FAIL single_k%0d: got en %b tag %0d val %h src %0d, required en %b tag 5 val 11 src 0",
                         k, obs_en, obs_tag, obs_val, obs_src, exp_en);
            end
        end
        for (int s = 0; s < NUM_SRC; s++) begin
            n_vec++;
            if (sb_q[s].size() != 0) begin
                n_err++;
                $display("FAIL single_drain src %0d: %0d pending, required 0", s, sb_q[s].size());
            end
        end
    endtask

    task automatic test_contention();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < NUM_SRC; s++)
                present(s, 4'(r*3 + s + 1), 32'h100 * (r + 1) + 32'(s));
            for (int k = 0; k < LAT + 3; k++) begin
                tick();
                n_vec++;
                if (k < LAT) begin
                    if (obs_en !== 1'b0) begin
                        n_err++;
                        $display("FAIL cont_r%0d_k%0d: got en %b, required 0", r, k, obs_en);
                    end
                end else if (obs_en !== 1'b1 || obs_src !== 2'(k - LAT) ||
                             obs_tag !== 4'(r*3 + k - LAT + 1)) begin
                    n_err++;
                    $display("FAIL cont_r%0d_k%0d: got en %b src %0d tag %0d, required en 1 src %0d tag %0d",
                             r, k, obs_en, obs_src, obs_tag, k - LAT, r*3 + k - LAT + 1);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        int cnt [NUM_SRC];
        bit done;
        for (int s = 0; s < NUM_SRC; s++) begin
            cnt[s] = 0;
            present(s, 4'(s*4), 32'hB000 + 32'(s*16));
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            if (cyc == 1) begin
                n_vec++;
`ifdef CDB_BYPASS_EN
                if (last_ready !== 3'b011) begin
                    n_err++;
                    $display("FAIL bp_ready: got %b, required 011", last_ready);
                end
`else
                if (last_ready !== 3'b001) begin
                    n_err++;
                    $display("FAIL bp_ready: got %b, required 001", last_ready);
                end
`endif
            end
            for (int s = 0; s < NUM_SRC; s++) begin
                if (last_acc[s]) begin
                    cnt[s]++;
                    if (cnt[s] < 4) present(s, 4'(s*4 + cnt[s]), 32'hB000 + 32'(s*16 + cnt[s]));
                end
            end
            done = 1'b1;
            for (int s = 0; s < NUM_SRC; s++)
                if (cnt[s] < 4 || sb_q[s].size() != 0) done = 1'b0;
            if (done) break;
        end
        for (int s = 0; s < NUM_SRC; s++) begin
            n_vec++;
            if (cnt[s] != 4 || sb_q[s].size() != 0) begin
                n_err++;
                $display("FAIL bp_complete src %0d: accepted %0d pending %0d, required 4 and 0",
                         s, cnt[s], sb_q[s].size());
            end
        end
    endtask

    task automatic test_roll_back();
        do_reset();
        for (int s = 0; s < NUM_SRC; s++) present(s, 4'(s + 1), 32'hA1 + 32'(s));
        for (int k = 0; k <= LAT; k++) tick();
        n_vec++;
        if (obs_en !== 1'b1 || obs_src !== 2'd0 || obs_tag !== 4'd1) begin
            n_err++;
            $display("FAIL rb_pre: got en %b src %0d tag %0d, required en 1 src 0 tag 1",
                     obs_en, obs_src, obs_tag);
        end
        roll_back = 1'b1;
        present(0, 4'hE, 32'hDEAD);
        clear_sb();
        tick();
        roll_back = 1'b0;
        bus.src_valid_in = '0;
        n_vec++;
        if (obs_en !== 1'b0) begin
            n_err++;
            $display("FAIL rb_en: got %b, required 0", obs_en);
        end
        n_vec++;
        if (last_ready !== 3'b000) begin
            n_err++;
            $display("FAIL rb_ready: got %b, required 000", last_ready);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++;
            if (obs_en !== 1'b0) begin
                n_err++;
                $display("FAIL rb_flushed_c%0d: got en %b tag %0d, required en 0", c, obs_en, obs_tag);
            end
        end
        present(2, 4'd7, 32'h77);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if (obs_en !== (k == LAT) ||
                ((k == LAT) && (obs_tag !== 4'd7 || obs_src !== 2'd2 || obs_val !== 32'h77))) begin
                n_err++;
                $display("FAIL rb_new_k%0d: got en %b tag %0d src %0d, required en %0d tag 7 src 2",
                         k, obs_en, obs_tag, obs_src, k == LAT);
            end
        end
    endtask

    task automatic test_stall();
        logic        h_en;
        logic [3:0]  h_tag;
        logic [31:0] h_val;
        logic [1:0]  h_src;
        do_reset();
        present(0, 4'd9, 32'h99);
        present(1, 4'd10, 32'hAA);
        tick();
`ifdef CDB_BYPASS_EN
        h_en = 1'b1; h_tag = 4'd9; h_val = 32'h99; h_src = 2'd0;
`else
        h_en = 1'b0; h_tag = 4'd0; h_val = 32'h0;  h_src = 2'd0;
`endif
        rdy_in = 1'b0;
        present(2, 4'd11, 32'hBB);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++;
            if (last_ready !== 3'b000) begin
                n_err++;
                $display("FAIL stall_ready_c%0d: got %b, required 000", c, last_ready);
            end
            n_vec++;
            if ({obs_en, obs_tag, obs_val, obs_src} !== {h_en, h_tag, h_val, h_src}) begin
                n_err++;
                $display("FAIL stall_hold_c%0d: got en %b tag %0d src %0d, required en %b tag %0d src %0d",
                         c, obs_en, obs_tag, obs_src, h_en, h_tag, h_src);
            end
        end
        rdy_in = 1'b1;
        tick();
        n_vec++;
`ifdef CDB_BYPASS_EN
        if (obs_en !== 1'b1 || obs_src !== 2'd1 || obs_tag !== 4'd10) begin
            n_err++;
            $display("FAIL stall_resume: got en %b src %0d tag %0d, required en 1 src 1 tag 10",
                     obs_en, obs_src, obs_tag);
        end
`else
        if (obs_en !== 1'b1 || obs_src !== 2'd0 || obs_tag !== 4'd9) begin
            n_err++;
            $display("FAIL stall_resume: got en %b src %0d tag %0d, required en 1 src 0 tag 9",
                     obs_en, obs_src, obs_tag);
        end
`endif
        for (int c = 0; c < 5; c++) tick();
        for (int s = 0; s < NUM_SRC; s++) begin
            n_vec++;
            if (sb_q[s].size() != 0) begin
                n_err++;
                $display("FAIL stall_drain src %0d: %0d pending, required 0", s, sb_q[s].size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_pressure();
        test_roll_back();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
